// File: rtl/serial_pkg.sv
// Shared definitions for the serial transmitter: FSM state encoding and the
// legal parameter ranges checked at elaboration by serial_tx_fifo.
// Optional feature macro: SERIAL_TX_PARITY_EN adds the PARITY state.
package serial_pkg;

    localparam int DATA_W_MIN    = 5;
    localparam int DATA_W_MAX    = 9;
    localparam int STOP_BITS_MIN = 1;
    localparam int STOP_BITS_MAX = 2;

`ifdef SERIAL_TX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } txState_t;
`else
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd4
    } txState_t;
`endif

endpackage

// File: rtl/tx_fifo.sv
// Word queue in front of the serial shifter. Writes are ignored while full,
// pops are ignored while empty; a simultaneous push and pop keeps the count.
// Pointers wrap naturally because FIFO_DEPTH is a power of two.
module tx_fifo #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          push,
    input  logic                          pop,
    input  logic [DATA_W-1:0]             din,
    output logic [DATA_W-1:0]             dout,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0]  rdPtr_q, rdPtr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              doPush;
    logic              doPop;

    assign full   = (count_q == CNT_W'(FIFO_DEPTH));
    assign empty  = (count_q == '0);
    assign count  = count_q;
    assign dout   = mem_q[rdPtr_q];
    assign doPush = push && !full;
    assign doPop  = pop && !empty;

    // Next pointer and occupancy values from the qualified push/pop strobes.
    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        if (doPush) begin
            wrPtr_d = wrPtr_q + PTR_W'(1);
        end
        if (doPop) begin
            rdPtr_d = rdPtr_q + PTR_W'(1);
        end
        case ({doPush, doPop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer/count registers; reset empties the queue.
    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
        end
    end

    // Storage captures din at enqueue so later input changes cannot leak in.
    always_ff @(posedge clk) begin
        if (doPush) begin
            mem_q[wrPtr_q] <= din;
        end
    end

endmodule

// File: rtl/serial_tx_fifo.sv
// Buffered serial transmitter: start bit, DATA_W data bits LSB first,
// optional parity, STOP_BITS stop bits; each bit lasts CLKS_PER_BIT clocks.
// Frames queued in tx_fifo go out back to back with no idle cycle.
// Optional feature macro: SERIAL_TX_PARITY_EN (parity bit, sense PARITY_ODD).
module serial_tx_fifo
    import serial_pkg::*;
#(
    parameter int CLKS_PER_BIT = 8,
    parameter int DATA_W       = 8,
    parameter int FIFO_DEPTH   = 4,
    parameter int STOP_BITS    = 1,
    parameter int PARITY_ODD   = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] data_in,
    output logic              tx,
    output logic              busy,
    output logic              done,
    output logic              full,
    output logic              overflow
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_W);

    if (DATA_W < DATA_W_MIN || DATA_W > DATA_W_MAX ||
        STOP_BITS < STOP_BITS_MIN || STOP_BITS > STOP_BITS_MAX ||
        CLKS_PER_BIT < 2 || PARITY_ODD < 0 || PARITY_ODD > 1 ||
        FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : gBadParams
        $error("serial_tx_fifo: illegal parameter combination");
    end

    txState_t                  state_q, state_d;
    logic [CNT_W-1:0]          clkCnt_q, clkCnt_d;
    logic [IDX_W-1:0]          bitIdx_q, bitIdx_d;
    logic [DATA_W-1:0]         shift_q, shift_d;
    logic                      tx_q, tx_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;
    logic                      overflow_q;
`ifdef SERIAL_TX_PARITY_EN
    logic                      parity_q, parity_d;
`endif

    logic                      fifoPop;
    logic                      fifoFull;
    logic                      fifoEmpty;
    logic [DATA_W-1:0]         fifoDout;
    // Occupancy is available from the queue but only empty/full matter here.
    logic [$clog2(FIFO_DEPTH):0] unusedFifoCount;
    logic                      bitEnd;
    logic                      loadFrame;

    tx_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) uFifo (
        .clk   (clk),
        .rst   (rst),
        .push  (start),
        .pop   (fifoPop),
        .din   (data_in),
        .dout  (fifoDout),
        .full  (fifoFull),
        .empty (fifoEmpty),
        .count (unusedFifoCount)
    );

    assign tx       = tx_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign full     = fifoFull;
    assign overflow = overflow_q;
    assign bitEnd   = (clkCnt_q == CNT_W'(CLKS_PER_BIT - 1));

    // Next-state logic: walks the frame bit by bit and reloads straight from
    // the queue at the end of STOP so consecutive frames have no gap.
    always_comb begin
        state_d   = state_q;
        clkCnt_d  = clkCnt_q;
        bitIdx_d  = bitIdx_q;
        shift_d   = shift_q;
        tx_d      = tx_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        fifoPop   = 1'b0;
        loadFrame = 1'b0;
`ifdef SERIAL_TX_PARITY_EN
        parity_d  = parity_q;
`endif

        if (state_q != IDLE) begin
            clkCnt_d = bitEnd ? '0 : clkCnt_q + CNT_W'(1);
        end

        case (state_q)
            IDLE: begin
                if (!fifoEmpty) begin
                    loadFrame = 1'b1;
                end
            end
            START: begin
                if (bitEnd) begin
                    state_d = DATA;
                    tx_d    = shift_q[0];
                end
            end
            DATA: begin
                if (bitEnd) begin
                    if (bitIdx_q == IDX_W'(DATA_W - 1)) begin
                        bitIdx_d = '0;
`ifdef SERIAL_TX_PARITY_EN
                        state_d  = PARITY;
                        tx_d     = parity_q;
`else
                        state_d  = STOP;
                        tx_d     = 1'b1;
`endif
                    end else begin
                        bitIdx_d = bitIdx_q + IDX_W'(1);
                        shift_d  = shift_q >> 1;
                        tx_d     = shift_q[1];
                    end
                end
            end
`ifdef SERIAL_TX_PARITY_EN
            PARITY: begin
                if (bitEnd) begin
                    state_d  = STOP;
                    tx_d     = 1'b1;
                    bitIdx_d = '0;
                end
            end
`endif
            STOP: begin
                if (bitEnd) begin
                    if (bitIdx_q == IDX_W'(STOP_BITS - 1)) begin
                        done_d   = 1'b1;
                        bitIdx_d = '0;
                        if (!fifoEmpty) begin
                            loadFrame = 1'b1;
                        end else begin
                            state_d = IDLE;
                            tx_d    = 1'b1;
                            busy_d  = 1'b0;
                        end
                    end else begin
                        bitIdx_d = bitIdx_q + IDX_W'(1);
                    end
                end
            end
            default: begin
                state_d  = IDLE;
                clkCnt_d = '0;
                bitIdx_d = '0;
                tx_d     = 1'b1;
                busy_d   = 1'b0;
            end
        endcase

        if (loadFrame) begin
            fifoPop  = 1'b1;
            state_d  = START;
            clkCnt_d = '0;
            bitIdx_d = '0;
            shift_d  = fifoDout;
            tx_d     = 1'b0;
            busy_d   = 1'b1;
`ifdef SERIAL_TX_PARITY_EN
            parity_d = (^fifoDout) ^ 1'(PARITY_ODD);
`endif
        end
    end

    // State and output registers; reset aborts any frame and idles the line.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            clkCnt_q   <= '0;
            bitIdx_q   <= '0;
            shift_q    <= '0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            clkCnt_q   <= clkCnt_d;
            bitIdx_q   <= bitIdx_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            overflow_q <= start && fifoFull;
`ifdef SERIAL_TX_PARITY_EN
            parity_q   <= parity_d;
`endif
        end
    end

endmodule

// File: tb/tb_serial_tx_fifo.sv
// Self-checking bench for serial_tx_fifo. Two instances share clock/reset:
// dut0 uses defaults, dut1 uses DATA_W=7, STOP_BITS=2, PARITY_ODD=1.
// A monitor per instance decodes each frame and compares it with the word
// queued when the start was driven. Honours SERIAL_TX_PARITY_EN.
module tb_serial_tx_fifo;

    localparam int CPB = 8;
`ifdef SERIAL_TX_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       start0, start1;
    logic [7:0] data0;
    logic [6:0] data1;
    logic       tx0, busy0, done0, full0, overflow0;
    logic       tx1, busy1, done1, full1, overflow1;
    logic [1:0] txV, busyV, doneV;

    logic [8:0] exp0[$];
    logic [8:0] exp1[$];

    int checks = 0;
    int failures = 0;
    int doneCnt0 = 0;
    int overflowCnt0 = 0;

    serial_tx_fifo #(
        .CLKS_PER_BIT (CPB), .DATA_W (8), .FIFO_DEPTH (4),
        .STOP_BITS (1), .PARITY_ODD (0)
    ) dut0 (
        .clk (clk), .rst (rst), .start (start0), .data_in (data0),
        .tx (tx0), .busy (busy0), .done (done0), .full (full0),
        .overflow (overflow0)
    );

    serial_tx_fifo #(
        .CLKS_PER_BIT (CPB), .DATA_W (7), .FIFO_DEPTH (4),
        .STOP_BITS (2), .PARITY_ODD (1)
    ) dut1 (
        .clk (clk), .rst (rst), .start (start1), .data_in (data1),
        .tx (tx1), .busy (busy1), .done (done1), .full (full1),
        .overflow (overflow1)
    );

    assign txV   = {tx1, tx0};
    assign busyV = {busy1, busy0};
    assign doneV = {done1, done0};

    // Free-running clock, 10 time units per cycle.
    always #5 clk = ~clk;

    // Pulse counters for dut0, sampled on the falling edge.
    always @(negedge clk) begin
        if (done0 === 1'b1) doneCnt0 <= doneCnt0 + 1;
        if (overflow0 === 1'b1) overflowCnt0 <= overflowCnt0 + 1;
    end

    // Single comparison point: counts the check and reports any failure.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Drive one start strobe (held across the next rising edge) and queue the
    // word as an expected frame when it should be accepted.
    task automatic applyStimulus(input int id, input logic [8:0] d, input bit accept);
        @(posedge clk);
        #1;
        if (id == 0) begin
            start0 = 1'b1;
            data0  = d[7:0];
            if (accept) exp0.push_back(d);
        end else begin
            start1 = 1'b1;
            data1  = d[6:0];
            if (accept) exp1.push_back(d);
        end
    endtask

    // Drop the strobes and scramble data_in so queued words must be held.
    task automatic releaseStart();
        @(posedge clk);
        #1;
        start0 = 1'b0;
        start1 = 1'b0;
        data0  = 8'($urandom);
        data1  = 7'($urandom);
    endtask

    // Wait, bounded, until all expected frames were seen and the DUT is idle.
    task automatic waitIdle(input int id, input int maxCycles, input string tag);
        int  n;
        bit  timedOut;
        n = 0;
        timedOut = 0;
        while (((id == 0) ? exp0.size() : exp1.size()) != 0 || busyV[id] !== 1'b0) begin
            @(posedge clk);
            #2;
            n++;
            if (n > maxCycles) begin
                timedOut = 1;
                break;
            end
        end
        checkOutput(tag, 32'(timedOut), 0);
    endtask

    // Frame decoder: from the first falling-edge sample with tx low, samples
    // each bit mid-period, checks busy/done over the whole frame and expects
    // done exactly frameBits*CPB samples after the start bit began.
    task automatic monitorLoop(input int id, input int dw, input int sb, input int podd);
        int         frameBits;
        logic [15:0] bits;
        logic [8:0] gotWord;
        logic [8:0] expWord;
        logic [8:0] mask;
        logic       expPar;
        bit         aborted, busyOk, doneQuiet, haveExp;
        frameBits = 1 + dw + PAR_BITS + sb;
        mask = (9'd1 << dw) - 9'd1;
        forever begin
            @(negedge clk);
            while (rst === 1'b0 && txV[id] === 1'b0) begin
                aborted = 0;
                busyOk = 1;
                doneQuiet = 1;
                bits = '0;
                for (int i = 0; i <= frameBits * CPB; i++) begin
                    if (i > 0) @(negedge clk);
                    if (rst !== 1'b0) begin
                        aborted = 1;
                        break;
                    end
                    if (i < frameBits * CPB) begin
                        if (i % CPB == CPB / 2) bits[i / CPB] = txV[id];
                        if (busyV[id] !== 1'b1) busyOk = 0;
                        if (i > 0 && doneV[id] !== 1'b0) doneQuiet = 0;
                    end
                end
                if (aborted) break;
                gotWord = '0;
                for (int j = 0; j < dw; j++) gotWord[j] = bits[1 + j];
                haveExp = ((id == 0) ? exp0.size() : exp1.size()) != 0;
                checkOutput("frame expected in queue", 32'(haveExp), 1);
                checkOutput("frame start bit", 32'(bits[0]), 0);
                if (haveExp) begin
                    expWord = (id == 0) ? exp0.pop_front() : exp1.pop_front();
                    expWord = expWord & mask;
                    checkOutput("frame data", 32'(gotWord), 32'(expWord));
`ifdef SERIAL_TX_PARITY_EN
                    expPar = (^expWord) ^ podd[0];
                    checkOutput("frame parity", 32'(bits[1 + dw]), 32'(expPar));
`endif
                end
                for (int s = 0; s < sb; s++)
                    checkOutput("frame stop bit", 32'(bits[1 + dw + PAR_BITS + s]), 1);
                checkOutput("busy during frame", 32'(busyOk), 1);
                checkOutput("done quiet mid-frame", 32'(doneQuiet), 1);
                checkOutput("done at frame end", 32'(doneV[id]), 1);
            end
        end
    endtask

    initial monitorLoop(0, 8, 1, 0);
    initial monitorLoop(1, 7, 2, 1);

    // Hard time limit so the bench always ends.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "[TB] watchdog");
    end

    // Directed sequence.
    initial begin
        int pulses;
        int gaps;
        int n;
        int doneBase;
        int ovfBase;

        rst = 1'b1;
        start0 = 1'b0;
        start1 = 1'b0;
        data0 = '0;
        data1 = '0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset tx", 32'(tx0), 1);
        checkOutput("reset busy", 32'(busy0), 0);
        checkOutput("reset done", 32'(done0), 0);
        checkOutput("reset full", 32'(full0), 0);
        checkOutput("reset overflow", 32'(overflow0), 0);
        checkOutput("reset tx dut1", 32'(tx1), 1);
        rst = 1'b0;

        $display("[TB] single frame 8'hA5 and start latency");
        doneBase = doneCnt0;
        applyStimulus(0, 9'h0A5, 1);
        @(posedge clk);
        #1;
        start0 = 1'b0;
        data0 = 8'h00;
        checkOutput("latency tx still idle", 32'(tx0), 1);
        @(posedge clk);
        #1;
        checkOutput("latency tx low", 32'(tx0), 0);
        checkOutput("latency busy high", 32'(busy0), 1);
        waitIdle(0, 300, "single frame drain");
        checkOutput("single busy after", 32'(busy0), 0);
        checkOutput("single tx after", 32'(tx0), 1);
        checkOutput("single done count", 32'(doneCnt0 - doneBase), 1);

        $display("[TB] back-to-back frames");
        applyStimulus(0, 9'h0A5, 1);
        applyStimulus(0, 9'h03C, 1);
        applyStimulus(0, 9'h0FF, 1);
        releaseStart();
        pulses = 0;
        gaps = 0;
        n = 0;
        while (pulses < 3 && n < 2000) begin
            @(negedge clk);
            n++;
            if (done0 === 1'b1) pulses++;
            else if (busy0 !== 1'b1) gaps++;
        end
        checkOutput("b2b done pulses", 32'(pulses), 3);
        checkOutput("b2b busy gaps", 32'(gaps), 0);
        waitIdle(0, 300, "b2b drain");

        $display("[TB] overflow with six starts");
        ovfBase = overflowCnt0;
        for (int k = 1; k <= 5; k++) applyStimulus(0, 9'(k * 17), 1);
        applyStimulus(0, 9'h066, 0);
        checkOutput("full before sixth", 32'(full0), 1);
        releaseStart();
        waitIdle(0, 1000, "overflow drain");
        checkOutput("overflow pulses", 32'(overflowCnt0 - ovfBase), 1);
        checkOutput("full after drain", 32'(full0), 0);

        $display("[TB] reset mid-frame");
        applyStimulus(0, 9'h0A5, 1);
        applyStimulus(0, 9'h03C, 1);
        releaseStart();
        repeat (32) @(posedge clk);
        #1;
        checkOutput("data bit 3 before reset", 32'(tx0), 0);
        doneBase = doneCnt0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("abort tx high", 32'(tx0), 1);
        checkOutput("abort busy low", 32'(busy0), 0);
        checkOutput("abort full low", 32'(full0), 0);
        rst = 1'b0;
        exp0.delete();
        repeat (100) @(posedge clk);
        #1;
        checkOutput("queued word discarded", 32'(busy0), 0);
        checkOutput("no done after abort", 32'(doneCnt0 - doneBase), 0);
        applyStimulus(0, 9'h03C, 1);
        releaseStart();
        waitIdle(0, 300, "post-reset frame drain");

        $display("[TB] DATA_W=7 STOP_BITS=2 frame 7'h55");
        applyStimulus(1, 9'h055, 1);
        releaseStart();
        waitIdle(1, 300, "dut1 frame drain");
        checkOutput("dut1 tx idle", 32'(tx1), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/serial_tx_fifo.md
SERIAL_TX_FIFO -- requirements
Module: serial_tx_fifo

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 8: clock cycles per serial bit, at least 2.
REQ-002 SHALL have parameter DATA_W, default 8: data bits per frame, range 5..9.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4: queued words, power of 2, at least 2.
REQ-004 SHALL have parameter STOP_BITS, default 1: stop bits per frame, 1 or 2.
REQ-005 SHALL have parameter PARITY_ODD, default 0: 0 selects even parity, 1 selects odd; used only when SERIAL_TX_PARITY_EN is defined.
REQ-006 SHALL have port clk, input, 1 bit: the single clock; all logic updates on its rising edge.
REQ-007 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-008 SHALL have port start, input, 1 bit: write strobe; data_in is enqueued when start=1 and full=0.
REQ-009 SHALL have port data_in, input, DATA_W bits: word to transmit.
REQ-010 SHALL have port tx, output, 1 bit: serial line, idle high.
REQ-011 SHALL have port busy, output, 1 bit: high while a frame is on the line.
REQ-012 SHALL have port done, output, 1 bit: one-cycle pulse at the end of each frame.
REQ-013 SHALL have port full, output, 1 bit: FIFO holds FIFO_DEPTH words.
REQ-014 SHALL have port overflow, output, 1 bit: one-cycle pulse one cycle after a start was dropped.

Function
REQ-015 The frame SHALL be: start bit 0; DATA_W data bits, LSB first; optional parity bit; STOP_BITS stop bits of 1. Each bit SHALL last exactly CLKS_PER_BIT cycles.
REQ-016 The FSM SHALL have states IDLE, START, DATA, PARITY and STOP; tx and busy SHALL be registered outputs.
REQ-017 IDLE with the FIFO not empty: the FSM SHALL pop one word, go to START, and drive tx=0 and busy=1 on the same edge.
REQ-018 Latency: with an empty FIFO in IDLE, a start sampled at edge k SHALL make tx=0 from edge k+1.
REQ-019 START SHALL go to DATA; after DATA_W bits, DATA SHALL go to PARITY (if enabled) or STOP; PARITY SHALL go to STOP.
REQ-020 At the end of STOP: done SHALL pulse high for one cycle. The FSM SHALL go to START with the next word if the FIFO is not empty (no idle cycle between frames), otherwise to IDLE with busy=0.
REQ-021 A write and a pop in the same cycle SHALL both take effect, leaving the count unchanged.
REQ-022 A start while full=1 SHALL be dropped and SHALL pulse overflow one cycle later. full is the registered value and does not account for a same-cycle pop.
REQ-023 The FIFO pointers SHALL wrap modulo FIFO_DEPTH; the count SHALL be $clog2(FIFO_DEPTH)+1 bits wide.
REQ-024 The bit-period counter SHALL count 0..CLKS_PER_BIT-1 and wrap; the bit index SHALL count 0..DATA_W-1.
REQ-025 data_in SHALL be captured at enqueue; later changes to data_in SHALL not affect a queued word.

Reset
REQ-026 With rst=1 at an edge, on that edge: tx=1, busy=0, done=0, full=0, overflow=0, FIFO empty, state IDLE, all counters 0.
REQ-027 Reset mid-frame SHALL abort the frame: no done pulse, queued words discarded, tx high from that edge; rst SHALL take priority over start.

Configuration
REQ-028 With the macro SERIAL_TX_PARITY_EN defined, the PARITY state SHALL send the XOR of the data bits (even), or its inverse when PARITY_ODD=1; frame length SHALL be (2+DATA_W+STOP_BITS)*CLKS_PER_BIT cycles.
REQ-029 Without SERIAL_TX_PARITY_EN, the PARITY state and its logic SHALL be absent; frame length SHALL be (1+DATA_W+STOP_BITS)*CLKS_PER_BIT cycles.

Structure
REQ-030 A shared package serial_pkg SHALL hold the FSM state typedef (IDLE..STOP) and the constants for the legal DATA_W and STOP_BITS ranges.
REQ-031 The FIFO SHALL be a sub-module tx_fifo (parameters DATA_W and FIFO_DEPTH; ports push, pop, din, dout, full, empty, count); the FSM and shifter SHALL stay in serial_tx_fifo.

Verification
REQ-032 Defaults, no parity, start with data_in=8'hA5 for one cycle -> tx bits 0,1,0,1,0,0,1,0,1,1, each 8 cycles; done pulses 80 cycles after tx falls; busy=0 afterwards.
REQ-033 SERIAL_TX_PARITY_EN, data 8'hA5 -> parity bit 0 with PARITY_ODD=0 and 1 with PARITY_ODD=1; frame lasts 88 cycles.
REQ-034 Starts of 8'hA5, 8'h3C, 8'hFF in consecutive cycles -> three frames with no idle gap between them, three done pulses, busy high throughout.
REQ-035 FIFO_DEPTH=4, six starts in consecutive cycles from idle -> five frames sent; the sixth word is dropped with exactly one overflow pulse.
REQ-036 rst=1 during data bit 3 of 8'hA5 with 8'h3C queued -> tx=1 and busy=0 on the next edge, no done, 8'h3C discarded; a following start of 8'h3C -> one complete, correct frame.
REQ-037 STOP_BITS=2, DATA_W=7, data 7'h55 -> tx 0,1,0,1,0,1,0,1,1,1; frame lasts 80 cycles.
